// File: rtl/fb_pkg.sv
// Shared constants for the frame-buffer port arbiter: address/data widths and host FSM encoding.
// No logic, so no latency.
// No handshakes, so no backpressure.
package fb_pkg;

  localparam int ADDR_W   = 13;      // per-bank word address (16 rows x 2 halves x 256 cols)
  localparam int DATA_W   = 16;      // pixel word (3x5-bit RGB + spare)
  localparam int BANK_BIT = ADDR_W;  // bank select is the MSB of the RAM address

  // Host access FSM encoding
  localparam logic [1:0] H_IDLE = 2'd0;
  localparam logic [1:0] H_WAIT = 2'd1;
  localparam logic [1:0] H_ACK  = 2'd2;

  // Forms the physical RAM address from a bank bit and a per-bank word address.
  function automatic logic [ADDR_W:0] bank_addr(input logic bank, input logic [ADDR_W-1:0] word);
    logic [ADDR_W:0] a;
    a           = {1'b0, word};
    a[BANK_BIT] = bank;
    return a;
  endfunction

endpackage

// File: rtl/fb_bank_swap.sv
// Double-buffer bank selector: arms on swap_req, flips front_sel only at a frame boundary.
// Latency: front_sel flips at the frame_done edge; swap_done pulses in the cycle after that edge.
// No backpressure: repeated swap requests while armed collapse into a single swap.
module fb_bank_swap (
  input  logic clk,
  input  logic rst,
  input  logic swap_req,
  input  logic frame_done,
  output logic swap_pending,
  output logic swap_done,
  output logic front_sel
);

  logic swap_exec;

  // A swap executes at a frame boundary when one is armed or is being requested right now.
  assign swap_exec = frame_done && (swap_pending || swap_req);

  // Arm/execute the swap; a request coinciding with execution is consumed, not re-armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      front_sel    <= 1'b0;
    end else begin
      swap_done <= swap_exec;
      if (swap_exec) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one synchronous-read frame-buffer RAM between the LED scanner (front bank) and a host (back bank).
// Latency: scanner read data visible 2 cycles after disp_req; host_ack 2 cycles after grant (grant/wait/ack).
// Backpressure: scanner always wins and is never stalled; host holds host_req until the host_ack pulse.
module fb_port_arbiter
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              frame_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_sel,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0] state;
  logic       host_rd;    // in-flight host access is a read
  logic       disp_pend;  // scanner read issued last cycle, data on ram_rdata now
  logic       grant;

  fb_bank_swap u_swap (
    .clk          (clk),
    .rst          (rst),
    .swap_req     (swap_req),
    .frame_done   (frame_done),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_sel    (front_sel)
  );

  // The host only gets the RAM in a cycle the scanner leaves free.
  assign grant    = (state == H_IDLE) && host_req && !disp_req;
  assign host_ack = (state == H_ACK);

  // RAM port mux: the scanner address by default, the host's back-bank access when granted.
  // The host bank is committed in the grant cycle because the RAM performs the access there,
  // so a swap during H_WAIT/H_ACK cannot redirect it.
  always_comb begin
    ram_addr  = bank_addr(front_sel, disp_addr);
    ram_we    = 1'b0;
    ram_wdata = host_wdata;
    if (grant) begin
      ram_addr = bank_addr(~front_sel, host_addr);
      ram_we   = host_we;
    end
  end

  // Host FSM: grant, wait one cycle for the synchronous RAM, then pulse ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= H_IDLE;
      host_rd    <= 1'b0;
      host_rdata <= '0;
    end else begin
      case (state)
        H_IDLE: begin
          if (grant) begin
            host_rd <= !host_we;
            state   <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (host_rd) host_rdata <= ram_rdata;
          state <= H_ACK;
        end
        H_ACK:   state <= H_IDLE;
        default: state <= H_IDLE;
      endcase
    end
  end

  // Scanner data capture: register RAM output one cycle after the strobe, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_pend <= 1'b0;
      disp_data <= '0;
    end else begin
      disp_pend <= disp_req;
      if (disp_pend) disp_data <= ram_rdata;
    end
  end

endmodule
